multibyte_add_seq: RTL and testbench
====================================

Name: multibyte_add_seq

Overview:
- Sequencer that performs wide additions (NBYTES×8 bits) by streaming byte slices through one shared eight_bit_adder instance, LSB byte first, with carry registered between bytes.
- Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.
- Trades latency for area: one adder, NBYTES cycles per operation.

Parameters:
- NBYTES, 4, number of byte slices per operand; legal range 1..16; W = 8*NBYTES.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set a, b, cin is valid.
- in_ready  output  1  block can accept an operand set.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into byte 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  registered result.
- cout  output  1  carry out of the top byte.

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, carry=0, a_reg=b_reg=0, sum=0, cout=0, out_valid=0, in_ready=1.
- States: IDLE, RUN, DONE. Encoding is 2 bits.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a→a_reg, b→b_reg; carry←cin; idx←0; sum←0; cout←0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Combinational inputs to the shared adder are a_reg[8*idx+:8], b_reg[8*idx+:8] and carry.
  - Each cycle: sum[8*idx+:8]←adder sum; carry←adder cout; idx←idx+1.
  - When idx==NBYTES-1: cout←adder cout; go to DONE.
  - With NBYTES=1, RUN lasts exactly one cycle.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout hold stable until out_valid&&out_ready.
  - On that handshake go to IDLE.
- Latency:
  - out_valid rises NBYTES+1 edges after the accepting edge (NBYTES RUN cycles, then DONE registered).
  - Throughput is one operation per NBYTES+2 cycles.
  - There is a mandatory one-cycle IDLE bubble between operations.
- in_valid asserted outside IDLE is ignored. The producer must hold its data until in_ready.
- Operands are captured at accept; changing a or b during RUN has no effect.
- Arithmetic is unsigned modulo 2^W; cout is the bit-W carry.
- Reset mid-operation: RUN/DONE aborted immediately, all outputs reset values, partial result discarded.
- idx width = clog2(NBYTES), minimum 1 bit; never exceeds NBYTES-1.
- During IDLE and RUN, the sum and cout outputs are don't-care to consumers. They are, however, deterministic as specified above.

Optional Feature:
- Macro: ADD_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered and reset to 0, cleared on accept.
  - In the final RUN cycle, ovf←(a_reg[W-1]==b_reg[W-1]) && (adder sum bit 7 != a_reg[W-1]), i.e. two's-complement signed overflow.
  - ovf is held through DONE with sum.
- Not defined: the port is absent and there is no ovf logic; all other behaviour is identical.

Decomposition:
- Shared include header holds:
  - state constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the byte width constant BYTE_W=8.
- Sub-module: the existing eight_bit_adder, instantiated once as the shared byte datapath. No new sub-module is needed.
- FSM, slice muxing and result registers live in multibyte_add_seq.

Test Plan:
- NBYTES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 → out_valid asserts 5 edges after accept; sum=0x00000000, cout=1.
- a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A, cout=0; in_ready=0 from accept until return to IDLE.
- Backpressure case:
  - Stimulus: a=0x000000FF, b=0x00000001; out_ready=0 for 6 cycles in DONE; second in_valid pulse meanwhile.
  - Response: sum=0x00000100 held stable, out_valid=1 throughout, second request not accepted; after out_ready=1, IDLE next cycle and in_ready=1.
- Reset mid-run: assert rst_n=0 after 2 RUN cycles → out_valid=0, sum=0, cout=0, in_ready=1 immediately (async). A new op a=5, b=7 after release gives sum=12.
- NBYTES=1: a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, out_valid 2 edges after accept.
- With ADD_SEQ_OVF_EN, NBYTES=4:
  - a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, ovf=1, cout=0.
  - a=0x80000000, b=0x80000000 → sum=0, cout=1, ovf=1.
  - a=0x00000002, b=0xFFFFFFFF → sum=0x00000001, ovf=0, cout=1.

Source files
------------

// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants for the multibyte add sequencer: FSM state encoding and byte width.
package multibyte_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/eight_bit_adder.sv
// Byte-wide ripple adder shared by the multibyte sequencer; purely combinational.
module eight_bit_adder
    import multibyte_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_sum,
    output logic              o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{BYTE_W{1'b0}}, i_cin};

endmodule

// File: rtl/multibyte_add_seq.sv
// Wide adder built by streaming byte slices, LSB first, through one shared eight_bit_adder.
// Optional macro ADD_SEQ_OVF_EN adds a registered signed-overflow output ovf.
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NBYTES*BYTE_W-1:0] a,
    input  logic [NBYTES*BYTE_W-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NBYTES*BYTE_W-1:0] sum,
    output logic                     cout
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int W     = NBYTES * BYTE_W;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              w_accept;
    logic              w_run;
    logic              w_last;
    logic [BYTE_W-1:0] w_add_sum;
    logic              w_add_cout;

    eight_bit_adder u_adder (
        .i_a    (r_a[r_idx*BYTE_W +: BYTE_W]),
        .i_b    (r_b[r_idx*BYTE_W +: BYTE_W]),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        w_last      = (r_idx == LAST_IDX);
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_carry <= cin;
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_run) begin
            r_sum[r_idx*BYTE_W +: BYTE_W] <= w_add_sum;
            r_carry <= w_add_cout;
            // idx parks on the top slice so it never leaves 0..NBYTES-1
            if (w_last) r_cout <= w_add_cout;
            else        r_idx  <= r_idx + 1'b1;
        end
    end

`ifdef ADD_SEQ_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_ovf <= 1'b0;
        else if (w_accept)        r_ovf <= 1'b0;
        else if (w_run && w_last) r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_add_sum[BYTE_W-1] != r_a[W-1]);
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq: a 4-byte and a 1-byte instance driven by directed vectors.
module tb_multibyte_add_seq;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, out_valid4, out_ready4 = 1'b1, cout4;
    logic [31:0] a4 = '0, b4 = '0, sum4;
    logic        in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, out_valid1, out_ready1 = 1'b1, cout1;
    logic [7:0]  a1 = '0, b1 = '0, sum1;
`ifdef ADD_SEQ_OVF_EN
    logic        ovf4, ovf1;
`endif

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges;

    always #5 clk = ~clk;

    multibyte_add_seq #(.NBYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4)
`ifdef ADD_SEQ_OVF_EN
        , .ovf(ovf4)
`endif
    );

    multibyte_add_seq #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef ADD_SEQ_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (q4.size() == 0) check("mon4_unexpected_result", q4.size(), 1);
            else begin
                e4 = q4.pop_front();
                check("mon4_sum", sum4, e4.sum);
                check("mon4_cout", cout4, e4.cout);
`ifdef ADD_SEQ_OVF_EN
                check("mon4_ovf", ovf4, e4.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) check("mon1_unexpected_result", q1.size(), 1);
            else begin
                e1 = q1.pop_front();
                check("mon1_sum", sum1, e1.sum[7:0]);
                check("mon1_cout", cout1, e1.cout);
`ifdef ADD_SEQ_OVF_EN
                check("mon1_ovf", ovf1, e1.ovf);
`endif
            end
        end
    end

    // Drives one operand set and returns just after the accepting edge.
    task automatic issue(input int sel, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((sel == 4) ? in_ready4 : in_ready1) break;
        end
        check("issue_in_ready", (sel == 4) ? in_ready4 : in_ready1, 1);
        if (sel == 4) begin in_valid4 = 1'b1; a4 = av; b4 = bv; cin4 = cv; end
        else          begin in_valid1 = 1'b1; a1 = av[7:0]; b1 = bv[7:0]; cin1 = cv; end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid; ends on a negedge.
    task automatic wait_done(input int sel, output int n);
        logic got;
        got = 1'b0;
        n   = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((sel == 4) ? out_valid4 : out_valid1) begin got = 1'b1; break; end
            check("busy_in_ready", (sel == 4) ? in_ready4 : in_ready1, 0);
            @(posedge clk);
            n++;
        end
        check("done_timeout", got, 1);
    endtask

    task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          input logic [31:0] es, input logic ec, input logic eo);
        int n;
        if (sel == 4) q4.push_back('{es, ec, eo});
        else          q1.push_back('{es, ec, eo});
        issue(sel, av, bv, cv);
        wait_done(sel, n);
        check("latency_edges", n, (sel == 4) ? 5 : 2);
        check("done_in_ready", (sel == 4) ? in_ready4 : in_ready1, 0);
        @(posedge clk);
        #1;
        check("back_to_idle_in_ready", (sel == 4) ? in_ready4 : in_ready1, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #22 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready4, 1);
        check("rst_out_valid", out_valid4, 0);
        check("rst_sum", sum4, 0);
        check("rst_cout", cout4, 0);

        run_op(4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op(4, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
        run_op(4, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 32'h0001_FFFE, 1'b0, 1'b0);
        run_op(4, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Backpressure: result held in DONE while a stray request is offered.
        out_ready4 = 1'b0;
        q4.push_back('{32'h0000_0100, 1'b0, 1'b0});
        issue(4, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done(4, edges);
        for (int c = 0; c < 6; c++) begin
            check("bp_out_valid", out_valid4, 1);
            check("bp_sum_held", sum4, 32'h0000_0100);
            check("bp_in_ready", in_ready4, 0);
            @(posedge clk);
            #1;
            if (c == 1) begin in_valid4 = 1'b1; a4 = 32'hDEAD_BEEF; b4 = 32'h0101_0101; end
            if (c == 2) in_valid4 = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", in_ready4, 1);
        check("bp_release_out_valid", out_valid4, 0);
        repeat (6) begin
            @(negedge clk);
            check("bp_stray_not_accepted", out_valid4, 0);
        end

        // Reset after two RUN cycles aborts the operation.
        issue(4, 32'h0000_1234, 32'h0000_4321, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid4, 0);
        check("midrst_sum", sum4, 0);
        check("midrst_cout", cout4, 0);
        check("midrst_in_ready", in_ready4, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0);

`ifdef ADD_SEQ_OVF_EN
        run_op(4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op(4, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_op(4, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
`endif

        run_op(1, 32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1);
        run_op(1, 32'h7F, 32'h01, 1'b1, 32'h81, 1'b0, 1'b1);
        run_op(1, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
